// File: rtl/hazard_sched_unit.sv
// rtl/hazard_sched_unit.sv - RV32 pipeline hazard controller and multi-cycle EX scheduler
module hazard_sched_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             BubbleM,
    output logic             MdBusy,
    output logic             MdDoneE,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Counter reload: the start cycle itself is one of the MD_LATENCY stall cycles.
    localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 1);

    md_state_t  state_q;
    md_state_t  state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       md_stall;
    logic       md_done;
    logic       md_busy;
    logic       lw_stall;
    logic       stall_fd;

    // M-stage result is newer than W-stage, so it wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m,
                                           input logic [4:0] rd_m,
                                           input logic       wr_w,
                                           input logic [4:0] rd_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // Multi-cycle op state register and down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multi-cycle sequencing: stall from the start cycle until the counter drains.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        md_done  = 1'b0;
        md_busy  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MdStartE) begin
                    state_d  = BUSY;
                    cnt_d    = MD_INIT;
                    md_stall = 1'b1;
                    md_busy  = 1'b1;
                end
            end
            BUSY: begin
                md_busy = 1'b1;
                if (cnt_q != 8'd0) begin
                    cnt_d    = cnt_q - 8'd1;
                    md_stall = 1'b1;
                end else begin
                    md_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load-use is masked while an op is in flight so FlushE cannot kill it.
    assign lw_stall = ResultSrcE && RegWriteE && (RD_E != 5'd0) &&
                      ((RD_E == Rs1D) || (RD_E == Rs2D)) && !md_stall;
    assign stall_fd = (lw_stall || md_stall) && !PCSrcE;

    // Output drive; reset forces bubbles into D/E and releases every stall at once.
    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b1;
        FlushE     = 1'b1;
        BubbleM    = 1'b0;
        MdBusy     = 1'b0;
        MdDoneE    = 1'b0;
        if (!rst) begin
            ForwardA_E = fwd_sel(Rs1E, RegWriteM, RD_M, RegWriteW, RD_W);
            ForwardB_E = fwd_sel(Rs2E, RegWriteM, RD_M, RegWriteW, RD_W);
            StallF     = stall_fd;
            StallD     = stall_fd;
            StallE     = md_stall;
            FlushD     = PCSrcE;
            FlushE     = PCSrcE || lw_stall;
            BubbleM    = md_stall;
            MdBusy     = md_busy;
            MdDoneE    = md_done;
        end
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= '0;
        end else if (StallF && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sched_unit.sv
// tb/tb_hazard_sched_unit.sv - directed scoreboard bench for hazard_sched_unit
module tb_hazard_sched_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RD_W;
    logic        RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MdStartE;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        StallF, StallD, StallE, FlushD, FlushE, BubbleM, MdBusy, MdDoneE;
    logic [15:0] StallCount;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_cnt = 16'd0;

    logic [11:0] exp_out_q[$];
    logic [15:0] exp_cnt_q[$];
    string       tag_q[$];

    hazard_sched_unit #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
        .MdBusy(MdBusy), .MdDoneE(MdDoneE), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RD_E = 5'd0; RD_M = 5'd0; RD_W = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 1'b0; PCSrcE = 1'b0; MdStartE = 1'b0;
    endtask

    task automatic set_load_use();
        ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7; Rs2D = 5'd7;
    endtask

    // Push the expected outputs for the inputs just driven, then pop and compare.
    task automatic chk(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                       input logic sf, input logic se, input logic fd, input logic fe,
                       input logic bm, input logic busy, input logic done);
        logic [11:0] exp_o;
        logic [11:0] got_o;
        logic [15:0] exp_c;
        string       t;
        if (rst) exp_cnt = 16'd0;
        tag_q.push_back(tag);
        exp_out_q.push_back({fa, fb, sf, sf, se, fd, fe, bm, busy, done});
        exp_cnt_q.push_back(exp_cnt);
        #1;
        t     = tag_q.pop_front();
        exp_o = exp_out_q.pop_front();
        exp_c = exp_cnt_q.pop_front();
        got_o = {ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
                 BubbleM, MdBusy, MdDoneE};
        total++;
        assert (got_o === exp_o) else begin
            bad++;
            $error("FAIL %s outputs got=%b exp=%b", t, got_o, exp_o);
        end
        total++;
        assert (StallCount === exp_c) else begin
            bad++;
            $error("FAIL %s_cnt got=%0d exp=%0d", t, StallCount, exp_c);
        end
        if (!rst && sf && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    // Hold MdStartE through four stall cycles and the done cycle, then release.
    task automatic md_run(input string tag, input logic lw_in_busy);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            MdStartE = 1'b1;
            if (lw_in_busy && i == 1) set_load_use();
            if (i == 2) begin ResultSrcE = 1'b0; RegWriteE = 1'b0; RD_E = 5'd0; Rs2D = 5'd0; end
            chk({tag, "_stall"}, 2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0);
        end
        @(negedge clk);
        chk({tag, "_done"}, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        MdStartE = 1'b0;
        chk({tag, "_idle"}, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        @(negedge clk);
        MdStartE = 1'b1;
        chk("reset", 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; MdStartE = 1'b0;
        chk("idle", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        RD_M = 5'd5; RegWriteM = 1'b1; RD_W = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
        chk("fwdA_m", 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        RegWriteM = 1'b0;
        chk("fwdA_w", 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        RegWriteM = 1'b1; Rs1E = 5'd3; Rs2E = 5'd5;
        chk("fwdB_m", 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        RD_M = 5'd0; RegWriteW = 1'b0; Rs2E = 5'd0;
        chk("x0_m", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        RegWriteW = 1'b1; RD_W = 5'd0; Rs1E = 5'd0;
        chk("x0_w", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        clear_inputs();
        set_load_use();
        chk("lw_use", 2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        clear_inputs();
        chk("lw_after", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        ResultSrcE = 1'b1; RD_E = 5'd7; Rs1D = 5'd7;
        chk("lw_nowr", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        clear_inputs();
        set_load_use(); PCSrcE = 1'b1;
        chk("lw_br", 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        clear_inputs();

        md_run("md", 1'b1);

        @(negedge clk);
        MdStartE = 1'b1;
        chk("md2_start", 2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_mid", 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; MdStartE = 1'b0;
        chk("rst_rel", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        md_run("md3", 1'b0);

        @(negedge clk);
        set_load_use();
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        chk("sat", 2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        clear_inputs();
        chk("sat_hold", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
